// File: rtl/riscv_soft_mem_arb.sv
// riscv_soft_mem_arb
//   Arbitrates the instruction-fetch and data request channels onto a single
//   memory port with at most one request outstanding. Grants are round-robin
//   when both requesters are valid; the priority bit starts out favouring the
//   data side.
//
// Ports
//   clk, reset              : single clock, asynchronous active-high reset
//   icache_req_*            : instruction fetch request (valid/ready/addr)
//   icache_resp_*           : instruction response (valid/data, 32 bits)
//   dcache_req_*            : data request (valid/ready/addr/op/op_type/data)
//   dcache_resp_*           : data response (valid/data)
//   mem_req_*               : shared memory request (valid/ready/addr/op/op_type/data)
//   mem_resp_*              : shared memory response (valid/data)
//
// Op encoding: 2'b00 load, 2'b01 store, 2'b10 fence. Every accepted request,
// including a fence, is completed by exactly one mem_resp_valid pulse.
module riscv_soft_mem_arb #(
  parameter int unsigned XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               icache_req_valid,
  output logic               icache_req_ready,
  input  logic [XPR_LEN-1:0] icache_req_addr,
  output logic               icache_resp_valid,
  output logic [31:0]        icache_resp_data,

  input  logic               dcache_req_valid,
  output logic               dcache_req_ready,
  input  logic [XPR_LEN-1:0] dcache_req_addr,
  input  logic [1:0]         dcache_req_op,
  input  logic [2:0]         dcache_req_op_type,
  input  logic [XPR_LEN-1:0] dcache_req_data,
  output logic               dcache_resp_valid,
  output logic [XPR_LEN-1:0] dcache_resp_data,

  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XPR_LEN-1:0] mem_req_addr,
  output logic [1:0]         mem_req_op,
  output logic [2:0]         mem_req_op_type,
  output logic [XPR_LEN-1:0] mem_req_data,
  input  logic               mem_resp_valid,
  input  logic [XPR_LEN-1:0] mem_resp_data
);

  localparam logic [1:0] MEM_LOAD    = 2'b00;
  localparam logic [2:0] IFETCH_TYPE = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 prio_dc_q, prio_dc_d;   // 1: dcache wins a tie
  logic                 owner_dc_q, owner_dc_d; // 1: outstanding request is dcache's
  logic [XPR_LEN-1:0]   addr_q, addr_d;
  logic [1:0]           op_q, op_d;
  logic [2:0]           op_type_q, op_type_d;
  logic [XPR_LEN-1:0]   data_q, data_d;

  logic                 grant_dc;
  logic                 grant_ic;
  logic                 in_idle;

  // The two grants are mutually exclusive by construction.
  always_comb begin
    grant_dc = dcache_req_valid && (!icache_req_valid ||  prio_dc_q);
    grant_ic = icache_req_valid && (!dcache_req_valid || !prio_dc_q);
  end

  // State is already IDLE while reset is held, so readys are explicitly
  // masked to keep the requesters from handshaking during reset.
  assign in_idle          = (state_q == IDLE) && !reset;
  assign dcache_req_ready = in_idle && grant_dc;
  assign icache_req_ready = in_idle && grant_ic;

  always_comb begin
    state_d    = state_q;
    prio_dc_d  = prio_dc_q;
    owner_dc_d = owner_dc_q;
    addr_d     = addr_q;
    op_d       = op_q;
    op_type_d  = op_type_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (grant_dc) begin
          addr_d     = dcache_req_addr;
          op_d       = dcache_req_op;
          op_type_d  = dcache_req_op_type;
          data_d     = dcache_req_data;
          owner_dc_d = 1'b1;
          prio_dc_d  = 1'b0;
          state_d    = ISSUE;
        end else if (grant_ic) begin
          addr_d     = icache_req_addr;
          op_d       = MEM_LOAD;
          op_type_d  = IFETCH_TYPE;
          data_d     = '0;
          owner_dc_d = 1'b0;
          prio_dc_d  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_dc_q  <= 1'b1;
      owner_dc_q <= 1'b0;
      addr_q     <= '0;
      op_q       <= '0;
      op_type_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      prio_dc_q  <= prio_dc_d;
      owner_dc_q <= owner_dc_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      op_type_q  <= op_type_d;
      data_q     <= data_d;
    end
  end

  assign mem_req_valid   = (state_q == ISSUE);
  assign mem_req_addr    = addr_q;
  assign mem_req_op      = op_q;
  assign mem_req_op_type = op_type_q;
  assign mem_req_data    = data_q;

  // Responses pass straight through in the cycle they arrive; data is
  // forced to zero whenever the matching valid is low.
  assign dcache_resp_valid = (state_q == WAIT) && mem_resp_valid &&  owner_dc_q;
  assign icache_resp_valid = (state_q == WAIT) && mem_resp_valid && !owner_dc_q;
  assign dcache_resp_data  = dcache_resp_valid ? mem_resp_data       : '0;
  assign icache_resp_data  = icache_resp_valid ? mem_resp_data[31:0] : '0;

endmodule

// File: tb/tb_riscv_soft_mem_arb.sv
// Scoreboard bench for riscv_soft_mem_arb: expected memory requests and
// routed responses are queued when stimulus is driven and compared when
// the DUT presents them. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_riscv_soft_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req_valid, icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        dcache_req_valid, dcache_req_ready;
  logic [31:0] dcache_req_addr;
  logic [1:0]  dcache_req_op;
  logic [2:0]  dcache_req_op_type;
  logic [31:0] dcache_req_data;
  logic        dcache_resp_valid;
  logic [31:0] dcache_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_op;
  logic [2:0]  mem_req_op_type;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  riscv_soft_mem_arb #(.XPR_LEN(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .dcache_req_valid  (dcache_req_valid),
    .dcache_req_ready  (dcache_req_ready),
    .dcache_req_addr   (dcache_req_addr),
    .dcache_req_op     (dcache_req_op),
    .dcache_req_op_type(dcache_req_op_type),
    .dcache_req_data   (dcache_req_data),
    .dcache_resp_valid (dcache_resp_valid),
    .dcache_resp_data  (dcache_resp_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_req_op        (mem_req_op),
    .mem_req_op_type   (mem_req_op_type),
    .mem_req_data      (mem_req_data),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic [2:0]  op_type;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit          dc;
    logic [31:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  bit          m_prio_dc;  // reference priority: 1 means dcache wins a tie

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ic_ready"}, icache_req_ready, 1'b0);
    check_eq({tag, "_dc_ready"}, dcache_req_ready, 1'b0);
    check_eq({tag, "_ic_rvalid"}, icache_resp_valid, 1'b0);
    check_eq({tag, "_dc_rvalid"}, dcache_resp_valid, 1'b0);
    check_eq({tag, "_ic_rdata"}, icache_resp_data, 32'h0);
    check_eq({tag, "_dc_rdata"}, dcache_resp_data, 32'h0);
  endtask

  task automatic clear_inputs();
    icache_req_valid   = 1'b0;
    icache_req_addr    = '0;
    dcache_req_valid   = 1'b0;
    dcache_req_addr    = '0;
    dcache_req_op      = '0;
    dcache_req_op_type = '0;
    dcache_req_data    = '0;
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;
  endtask

  // Entered and left on a falling edge with the DUT idle.
  task automatic run_txn(input bit ic_v, input bit dc_v,
                         input logic [31:0] ic_a, input logic [31:0] dc_a,
                         input logic [1:0] dc_op, input logic [2:0] dc_ot,
                         input logic [31:0] dc_d, input int unsigned stall,
                         input logic [31:0] rdata);
    bit          win_dc;
    req_t        r;
    rsp_t        s;
    int unsigned waited;

    icache_req_valid   = ic_v;
    icache_req_addr    = ic_a;
    dcache_req_valid   = dc_v;
    dcache_req_addr    = dc_a;
    dcache_req_op      = dc_op;
    dcache_req_op_type = dc_ot;
    dcache_req_data    = dc_d;

    win_dc = dc_v && (!ic_v || m_prio_dc);
    if (win_dc) r = '{dc_a, dc_op, dc_ot, dc_d};
    else        r = '{ic_a, 2'b00, 3'b010, 32'h0};
    exp_req_q.push_back(r);
    exp_rsp_q.push_back('{win_dc, rdata});
    m_prio_dc = !win_dc;

    #1;
    check_eq("grant_dc_ready", dcache_req_ready, win_dc);
    check_eq("grant_ic_ready", icache_req_ready, !win_dc);
    check_eq("idle_mreq_valid", mem_req_valid, 1'b0);

    @(posedge clk);
    @(negedge clk);
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    mem_req_ready    = 1'b0;
    waited = 1;
    while (!mem_req_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq("req_latency", waited, 1);
    r = exp_req_q.pop_front();

    // Stall cycles: requesters and a stray response are pushed at the DUT,
    // which must hold the request steady and ignore both.
    for (int unsigned i = 0; i < stall; i++) begin
      icache_req_valid = 1'b1;
      dcache_req_valid = 1'b1;
      mem_resp_valid   = 1'b1;
      mem_resp_data    = 32'hBAD0_0000 | i;
      #1;
      check_eq("stall_mreq_valid", mem_req_valid, 1'b1);
      check_eq("stall_addr", mem_req_addr, r.addr);
      check_eq("stall_op", mem_req_op, r.op);
      check_eq("stall_data", mem_req_data, r.data);
      check_quiet("stall");
      @(negedge clk);
      icache_req_valid = 1'b0;
      dcache_req_valid = 1'b0;
      mem_resp_valid   = 1'b0;
      mem_resp_data    = '0;
    end

    mem_req_ready = 1'b1;
    #1;
    check_eq("issue_mreq_valid", mem_req_valid, 1'b1);
    check_eq("issue_addr", mem_req_addr, r.addr);
    check_eq("issue_op", mem_req_op, r.op);
    check_eq("issue_op_type", mem_req_op_type, r.op_type);
    check_eq("issue_data", mem_req_data, r.data);
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check_eq("wait_mreq_valid", mem_req_valid, 1'b0);

    s = exp_rsp_q.pop_front();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    #1;
    check_eq("rsp_dc_valid", dcache_resp_valid, s.dc);
    check_eq("rsp_ic_valid", icache_resp_valid, !s.dc);
    check_eq("rsp_dc_data", dcache_resp_data, s.dc ? s.data : 32'h0);
    check_eq("rsp_ic_data", icache_resp_data, s.dc ? 32'h0 : s.data);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    check_eq("post_rsp_dc_valid", dcache_resp_valid, 1'b0);
    check_eq("post_rsp_ic_valid", icache_resp_valid, 1'b0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    m_prio_dc = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_prio_dc = 1'b1;
    @(negedge clk);
    // Everything asserted while reset is held: nothing may respond.
    icache_req_valid = 1'b1;
    dcache_req_valid = 1'b1;
    mem_req_ready    = 1'b1;
    mem_resp_valid   = 1'b1;
    mem_resp_data    = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("rst_mreq_valid", mem_req_valid, 1'b0);
    check_eq("rst_mreq_addr", mem_req_addr, 32'h0);
    check_eq("rst_mreq_op", mem_req_op, 2'b00);
    check_quiet("rst");
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);

    // Single dcache load.
    run_txn(1'b0, 1'b1, 32'h0, 32'h100, 2'b00, 3'b010, 32'h0, 0, 32'hDEAD_BEEF);

    // Simultaneous requests from reset alternate dcache, icache, dcache.
    apply_reset();
    run_txn(1'b1, 1'b1, 32'h200, 32'h300, 2'b00, 3'b010, 32'h0, 0, 32'h1111_0001);
    run_txn(1'b1, 1'b1, 32'h204, 32'h304, 2'b00, 3'b010, 32'h0, 0, 32'h2222_0002);
    run_txn(1'b1, 1'b1, 32'h208, 32'h308, 2'b00, 3'b010, 32'h0, 0, 32'h3333_0003);

    // Memory port back-pressure for three cycles.
    run_txn(1'b0, 1'b1, 32'h0, 32'h80, 2'b00, 3'b100, 32'h0, 3, 32'h0BAD_CAFE);
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 2'b00, 3'b000, 32'h0, 2, 32'h5555_AAAA);

    // Store and fence each complete with one response.
    run_txn(1'b0, 1'b1, 32'h0, 32'h40, 2'b01, 3'b010, 32'h1234_5678, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 2'b10, 3'b000, 32'h0, 1, 32'h0);

    // Reset while waiting for a response abandons the transaction.
    dcache_req_valid = 1'b1;
    dcache_req_addr  = 32'h500;
    @(posedge clk);
    @(negedge clk);
    dcache_req_valid = 1'b0;
    mem_req_ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check_eq("pre_rst_wait_mreq_valid", mem_req_valid, 1'b0);
    reset            = 1'b1;
    m_prio_dc        = 1'b1;
    dcache_req_valid = 1'b1;
    icache_req_valid = 1'b1;
    #1;
    check_eq("midrst_mreq_valid", mem_req_valid, 1'b0);
    check_eq("midrst_mreq_addr", mem_req_addr, 32'h0);
    check_quiet("midrst");
    @(negedge clk);
    reset            = 1'b0;
    dcache_req_valid = 1'b0;
    icache_req_valid = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    #1;
    check_quiet("late_rsp");
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    run_txn(1'b1, 1'b0, 32'h600, 32'h0, 2'b00, 3'b000, 32'h0, 0, 32'h6060_6060);

    // Spurious response while idle.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    #1;
    check_quiet("spurious");
    check_eq("spurious_mreq_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    // Still idle and granting afterwards.
    run_txn(1'b1, 1'b1, 32'h700, 32'h704, 2'b00, 3'b010, 32'h0, 0, 32'h7070_7070);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_soft_mem_arb.md
RISCV_SOFT_MEM_ARB -- requirements
Module: riscv_soft_mem_arb

Interface
REQ-001 SHALL have parameter: XPR_LEN, 32, width of address and data buses.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: icache_req_valid input 1 / icache_req_ready output 1 / icache_req_addr input XPR_LEN  instruction fetch request channel.
REQ-005 SHALL have ports: icache_resp_valid output 1 / icache_resp_data output 32  instruction response channel.
REQ-006 SHALL have ports: dcache_req_valid input 1 / dcache_req_ready output 1 / dcache_req_addr input XPR_LEN / dcache_req_op input 2 / dcache_req_op_type input 3 / dcache_req_data input XPR_LEN  data request channel.
REQ-007 SHALL have ports: dcache_resp_valid output 1 / dcache_resp_data output XPR_LEN  data response channel.
REQ-008 SHALL have ports: mem_req_valid output 1 / mem_req_ready input 1 / mem_req_addr output XPR_LEN / mem_req_op output 2 / mem_req_op_type output 3 / mem_req_data output XPR_LEN  shared memory request port.
REQ-009 SHALL have ports: mem_resp_valid input 1 / mem_resp_data input XPR_LEN  shared memory response port.

Function
REQ-010 SHALL use op encoding MEM_LOAD=2'b00, MEM_STORE=2'b01, MEM_FENCE=2'b10; every accepted memory request (load, store, fence) yields exactly one mem_resp_valid pulse.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one request outstanding on the memory port.
REQ-012 SHALL, in IDLE, assert req_ready only to the granted requester, combinationally from the valids and a registered priority bit; both readys low in ISSUE and WAIT.
REQ-013 SHALL grant: only one valid -> that one; both valid -> requester not granted last (round-robin); priority bit initialised to favour dcache.
REQ-014 SHALL, on grant handshake (valid && ready in IDLE), latch addr/op/op_type/data and owner into registers, toggle priority away from winner, go to ISSUE next cycle.
REQ-015 SHALL drive icache requests as op=MEM_LOAD, op_type=3'b010, data=0.
REQ-016 SHALL, in ISSUE, hold mem_req_valid=1 with stable latched fields until mem_req_ready=1, then go to WAIT; mem_req_valid=0 in IDLE and WAIT.
REQ-017 SHALL, in WAIT, on mem_resp_valid pulse the owner's resp_valid for that same cycle with resp_data = mem_resp_data (combinational pass-through), other resp_valid low, and return to IDLE.
REQ-018 SHALL ignore mem_resp_valid in IDLE and ISSUE (no resp_valid output).
REQ-019 SHALL give latency: request accepted cycle N -> mem_req_valid in N+1; earliest next grant the cycle after the response.
REQ-020 SHALL hold resp_data outputs at 0 when the corresponding resp_valid is low.

Reset
REQ-021 SHALL, on reset assertion (any state, including mid-transaction), go immediately to IDLE, abandon the outstanding request, and drive all outputs 0; latched fields clear to 0, priority favours dcache.
REQ-022 SHALL, with reset held, assert no ready, valid or resp output regardless of inputs.

Verification
REQ-023 SHALL cover: dcache load addr 0x100, mem_req_ready=1, resp 0xDEADBEEF two cycles later -> mem_req_valid one cycle after accept with op=00, dcache_resp_valid one cycle with data 0xDEADBEEF, icache_resp_valid 0.
REQ-024 SHALL cover: icache and dcache valid simultaneously from reset, repeated -> grants alternate dcache, icache, dcache; each response routed to its owner only.
REQ-025 SHALL cover: mem_req_ready low 3 cycles in ISSUE -> mem_req_valid held 4 cycles, addr/op/data unchanged, both readys 0.
REQ-026 SHALL cover: dcache store addr 0x40 data 0x12345678 op_type 3'b010 -> mem port shows op=01 with those fields; ack pulse -> dcache_resp_valid 1 cycle.
REQ-027 SHALL cover: reset asserted in WAIT, then mem_resp_valid after release -> no resp_valid pulses, FSM in IDLE, next request served normally.
REQ-028 SHALL cover: spurious mem_resp_valid in IDLE -> no icache/dcache resp_valid.
